// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N byte producers.
// Supports per-requester lock for multi-byte frames and an optional idle gap after each byte.
module uart_tx_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int GAP = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [8*N-1:0] din_all,
  output logic [N-1:0]   ack,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           tx_start,
  output logic [7:0]     tx_din,
  input  logic           tx_done_tick
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t         state_r, state_nxt;
  logic [IDW-1:0] rr_ptr_r, rr_ptr_nxt;
  logic [IDW-1:0] grant_r, grant_nxt;
  logic           hold_r, hold_nxt;
  logic [7:0]     gap_cnt_r, gap_cnt_nxt;
  logic [7:0]     tx_din_r, tx_din_nxt;
  logic [N-1:0]   ack_r, ack_nxt;
  logic           tx_start_r;
  logic           busy_r;
  logic [IDW:0]   pick_s;
  logic [7:0]     din_bytes_s [N];

  // Returns {found, index} of the first set request after ptr, wrapping modulo N.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] ptr);
    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    int             idx;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      cand = idx[IDW-1:0];
      if (!found && r[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    return {found, win};
  endfunction

  // Unpack the flat per-requester byte bus.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      din_bytes_s[i] = din_all[8*i +: 8];
    end
  end

  // Next-state logic; data register doubles as the tx_din output register.
  always_comb begin
    state_nxt   = state_r;
    rr_ptr_nxt  = rr_ptr_r;
    grant_nxt   = grant_r;
    hold_nxt    = hold_r;
    gap_cnt_nxt = gap_cnt_r;
    tx_din_nxt  = tx_din_r;
    pick_s      = rr_pick(req, rr_ptr_r);
    case (state_r)
      ST_IDLE: begin
        // hold only survives one IDLE decision: used here or discarded
        hold_nxt = 1'b0;
        if (hold_r && req[grant_r]) begin
          state_nxt  = ST_LOAD;
          tx_din_nxt = din_bytes_s[grant_r];
        end else if (pick_s[IDW]) begin
          state_nxt  = ST_LOAD;
          grant_nxt  = pick_s[IDW-1:0];
          rr_ptr_nxt = pick_s[IDW-1:0];
          tx_din_nxt = din_bytes_s[pick_s[IDW-1:0]];
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_tick) begin
          hold_nxt = lock[grant_r];
          if (GAP == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt   = ST_GAP;
            gap_cnt_nxt = 8'(GAP);
          end
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r <= 8'd1) begin
          state_nxt   = ST_IDLE;
          gap_cnt_nxt = 8'd0;
        end else begin
          gap_cnt_nxt = gap_cnt_r - 8'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // One-hot ack for the requester entering LOAD.
  always_comb begin
    ack_nxt = '0;
    if (state_nxt == ST_LOAD) begin
      ack_nxt[grant_nxt] = 1'b1;
    end else begin
      ack_nxt = '0;
    end
  end

  // State and registered Moore outputs, aligned with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= IDW'(N - 1);
      grant_r    <= '0;
      hold_r     <= 1'b0;
      gap_cnt_r  <= 8'd0;
      tx_din_r   <= 8'd0;
      ack_r      <= '0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      rr_ptr_r   <= rr_ptr_nxt;
      grant_r    <= grant_nxt;
      hold_r     <= hold_nxt;
      gap_cnt_r  <= gap_cnt_nxt;
      tx_din_r   <= tx_din_nxt;
      ack_r      <= ack_nxt;
      tx_start_r <= (state_nxt == ST_LOAD);
      busy_r     <= (state_nxt != ST_IDLE);
    end
  end

  assign ack      = ack_r;
  assign grant_id = grant_r;
  assign busy     = busy_r;
  assign tx_start = tx_start_r;
  assign tx_din   = tx_din_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; dut uses GAP=0, dut_gap uses GAP=4.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] din_all;
  logic        tx_done_tick;

  logic [3:0] ack, g_ack;
  logic [1:0] grant_id, g_grant_id;
  logic       busy, g_busy, tx_start, g_tx_start;
  logic [7:0] tx_din, g_tx_din;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(4), .IDW(2), .GAP(0)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .din_all(din_all),
    .ack(ack), .grant_id(grant_id), .busy(busy), .tx_start(tx_start),
    .tx_din(tx_din), .tx_done_tick(tx_done_tick)
  );

  uart_tx_arbiter #(.N(4), .IDW(2), .GAP(4)) dut_gap (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .din_all(din_all),
    .ack(g_ack), .grant_id(g_grant_id), .busy(g_busy), .tx_start(g_tx_start),
    .tx_din(g_tx_din), .tx_done_tick(tx_done_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; req = 4'd0; lock = 4'd0; din_all = 32'd0; tx_done_tick = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Bounded search for the next tx_start on dut.
  task automatic wait_start(output int id, output logic [7:0] data, output logic [3:0] a, output bit ok);
    ok = 1'b0; id = 0; data = 8'd0; a = 4'd0;
    for (int k = 0; k < 20; k++) begin
      if (tx_start === 1'b1) begin
        ok = 1'b1; id = int'(grant_id); data = tx_din; a = ack;
        break;
      end
      step();
    end
  endtask

  // From the LOAD cycle: two WAIT cycles, done tick in the second, ends in the following cycle.
  task automatic finish_byte();
    step();
    step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if ({ack, grant_id, busy, tx_start, tx_din} !== 16'd0) $display("FAIL reset_dut: got %h expected 0", {ack, grant_id, busy, tx_start, tx_din}); else passed++;
    total++; if ({g_ack, g_grant_id, g_busy, g_tx_start, g_tx_din} !== 16'd0) $display("FAIL reset_dut_gap: got %h expected 0", {g_ack, g_grant_id, g_busy, g_tx_start, g_tx_din}); else passed++;
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0010; din_all[15:8] = 8'h41;
    step();
    total++; if (ack !== 4'b0010) $display("FAIL single_ack: got %b expected 0010", ack); else passed++;
    total++; if (tx_start !== 1'b1) $display("FAIL single_start: got %b expected 1", tx_start); else passed++;
    total++; if (tx_din !== 8'h41) $display("FAIL single_din: got %h expected 41", tx_din); else passed++;
    total++; if (grant_id !== 2'd1) $display("FAIL single_grant: got %0d expected 1", grant_id); else passed++;
    req = 4'b0000;
    step();
    total++; if ({tx_start, ack} !== 5'd0) $display("FAIL single_wait_pulse: got %b expected 0", {tx_start, ack}); else passed++;
    total++; if (busy !== 1'b1 || tx_din !== 8'h41) $display("FAIL single_wait_hold: got busy=%b din=%h expected 1/41", busy, tx_din); else passed++;
    step();
    step();
    step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_round_robin();
    int id; logic [7:0] d; logic [3:0] a; bit ok; int extra;
    logic [7:0] exp_d; logic [3:0] exp_a;
    apply_reset();
    din_all = 32'h1312_1110;
    req = 4'b1111;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      wait_start(id, d, a, ok);
      exp_d = 8'h10 + 8'(i);
      exp_a = 4'b0001 << i;
      total++; if (!ok) $display("FAIL rr_timeout[%0d]: got no tx_start expected one", i); else passed++;
      total++; if (id != i) $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, id, i); else passed++;
      total++; if (d !== exp_d || a !== exp_a) $display("FAIL rr_data[%0d]: got %h/%b expected %h/%b", i, d, a, exp_d, exp_a); else passed++;
      req[i] = 1'b0;
      step();
      if (tx_start !== 1'b0) extra++;
      step();
      if (tx_start !== 1'b0) extra++;
      tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
      if (tx_start !== 1'b0) extra++;
    end
    total++; if (extra != 0) $display("FAIL rr_extra_starts: got %0d expected 0", extra); else passed++;
  endtask

  task automatic test_fairness();
    int id; logic [7:0] d; logic [3:0] a; bit ok;
    int exp_ids [4] = '{0, 2, 0, 2};
    apply_reset();
    din_all = 32'h00A2_00A0;
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_start(id, d, a, ok);
      total++; if (!ok || id != exp_ids[i]) $display("FAIL fair_grant[%0d]: got %0d ok=%0d expected %0d", i, id, ok, exp_ids[i]); else passed++;
      finish_byte();
    end
    req = 4'b0000;
  endtask

  task automatic test_lock();
    int id; logic [7:0] d; logic [3:0] a; bit ok;
    int exp_ids [4] = '{1, 1, 1, 3};
    apply_reset();
    din_all = 32'hD300_D100;
    req = 4'b1010;
    lock = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      wait_start(id, d, a, ok);
      total++; if (!ok || id != exp_ids[i]) $display("FAIL lock_grant[%0d]: got %0d ok=%0d expected %0d", i, id, ok, exp_ids[i]); else passed++;
      if (i == 2) lock = 4'b0000;
      finish_byte();
    end
    req = 4'b0000;
  endtask

  task automatic test_gap();
    bit ok;
    apply_reset();
    din_all = 32'hB300_00B0;
    req = 4'b1001;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (g_tx_start === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    total++; if (!ok || g_grant_id !== 2'd0) $display("FAIL gap_first: got grant=%0d ok=%0d expected 0", g_grant_id, ok); else passed++;
    req[0] = 1'b0;
    step();
    step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    total++; if (g_busy !== 1'b1 || g_tx_start !== 1'b0) $display("FAIL gap_t1: got busy=%b start=%b expected 1/0", g_busy, g_tx_start); else passed++;
    step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    total++; if (g_tx_start !== 1'b0) $display("FAIL gap_spurious: got start=%b expected 0", g_tx_start); else passed++;
    step();
    total++; if (g_busy !== 1'b1) $display("FAIL gap_t4_busy: got %b expected 1", g_busy); else passed++;
    step();
    total++; if (g_busy !== 1'b0 || g_tx_start !== 1'b0) $display("FAIL gap_t5_idle: got busy=%b start=%b expected 0/0", g_busy, g_tx_start); else passed++;
    step();
    total++; if (g_tx_start !== 1'b1 || g_grant_id !== 2'd3 || g_tx_din !== 8'hB3) $display("FAIL gap_t6_start: got start=%b grant=%0d din=%h expected 1/3/b3", g_tx_start, g_grant_id, g_tx_din); else passed++;
    req = 4'b0000;
    step();
    step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    for (int k = 0; k < 4; k++) step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    total++; if (g_busy !== 1'b0 || g_tx_start !== 1'b0) $display("FAIL gap_idle_tick: got busy=%b start=%b expected 0/0", g_busy, g_tx_start); else passed++;
    step();
    total++; if (g_busy !== 1'b0 || g_tx_start !== 1'b0) $display("FAIL gap_idle_tick2: got busy=%b start=%b expected 0/0", g_busy, g_tx_start); else passed++;
  endtask

  task automatic test_reset_mid();
    int id; logic [7:0] d; logic [3:0] a; bit ok;
    apply_reset();
    req = 4'b0100;
    din_all = 32'h00C2_0000;
    step();
    req = 4'b0000;
    step();
    total++; if (busy !== 1'b1 || grant_id !== 2'd2) $display("FAIL mid_pre: got busy=%b grant=%0d expected 1/2", busy, grant_id); else passed++;
    reset = 1'b1;
    #1;
    total++; if ({tx_start, ack, busy} !== 6'd0) $display("FAIL mid_reset_out: got %b expected 0", {tx_start, ack, busy}); else passed++;
    total++; if (grant_id !== 2'd0 || tx_din !== 8'd0) $display("FAIL mid_reset_regs: got grant=%0d din=%h expected 0/00", grant_id, tx_din); else passed++;
    req = 4'b1010;
    din_all = 32'hC300_5A00;
    step();
    step();
    reset = 1'b0;
    total++; if ({tx_start, ack} !== 5'd0) $display("FAIL mid_release: got %b expected 0", {tx_start, ack}); else passed++;
    step();
    total++; if (tx_start !== 1'b1 || grant_id !== 2'd1 || tx_din !== 8'h5A || ack !== 4'b0010) $display("FAIL mid_first: got start=%b grant=%0d din=%h ack=%b expected 1/1/5a/0010", tx_start, grant_id, tx_din, ack); else passed++;
    req[1] = 1'b0;
    finish_byte();
    wait_start(id, d, a, ok);
    total++; if (!ok || id != 3 || d !== 8'hC3) $display("FAIL mid_second: got %0d/%h ok=%0d expected 3/c3", id, d, ok); else passed++;
    req = 4'b0000;
    finish_byte();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = 4'd0; lock = 4'd0; din_all = 32'd0; tx_done_tick = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_lock();
    test_gap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
